mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised MEM pipeline stage for the LA CPU, placed between EX and WB.
//  - Waits for the data-RAM response of any request that EX issued.
//  - Extracts and sign- or zero-extends sub-word loads.
//  - Buffers returned data while WB stalls.
//  - Supports flush, including discarding a response still in flight.
//  - Drives a forwarding/interlock bus to decode.
// PARAMETERS
//  DATA_W  32  datapath/GPR width; legal values 32 or 64 (64 enables LD_D/LD_WU)
//  REG_AW  5   GPR index width
//  PC_W    32  PC width
// PORTS
//  clk             in   1              clock
//  resetn          in   1              synchronous reset, active-low
//  ws_allowin      in   1              WB can accept
//  ms_allowin      out  1              MEM can accept
//  es_to_ms_valid  in   1              EX bus valid
//  es_to_ms_bus    in   ES_TO_MS_W     {req_issued,ld_op[2:0],res_from_mem,gr_we,dest,alu_result,pc}
//  ms_flush        in   1              kill MEM contents (exception/ertn from WB)
//  data_ok         in   1              data-RAM response strobe, 1 cycle per issued request
//  data_rdata      in   DATA_W         response data, valid with data_ok
//  ms_to_ws_valid  out  1              to WB valid
//  ms_to_ws_bus    out  MS_TO_WS_W     {gr_we,dest,final_result,pc}
//  ms_to_ds_fwd    out  MS_FWD_W       {fwd_valid,fwd_block,dest,final_result}
// BEHAVIOUR
//  Reset (resetn==0 at posedge):
//   - ms_valid=0, buf_valid=0, cancel_pend=0.
//   - All valid outputs are 0; ms_to_ds_fwd is all-zero.
//  Capture: es_to_ms_bus_r <= es_to_ms_bus when es_to_ms_valid && ms_allowin.
//   - ms_valid <= es_to_ms_valid when ms_allowin.
//   - ms_valid <= 0 on ms_flush; flush has priority over capture.
//  Wait condition: need_resp = ms_valid && req_issued.
//   - resp_here = buf_valid || (data_ok && !cancel_pend).
//   - ms_ready_go = !need_resp || resp_here.
//   - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
//   - ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush.
//  Latency: zero-wait response -> MEM occupies 1 cycle.
//   - Each data_ok cycle late adds 1 cycle.
//   - Combinational path data_rdata -> ms_to_ws_bus is permitted.
//  Response buffer (1 entry):
//   - Set when data_ok && !cancel_pend && need_resp && !ws_allowin; rdata_buf <= data_rdata.
//   - Cleared when the instruction hands off (ms_to_ws_valid && ws_allowin) or on flush.
//   - Selection: raw data = buf_valid ? rdata_buf : data_rdata.
//  Flush while waiting (need_resp && !resp_here && ms_flush):
//   - Set cancel_pend; the next data_ok is dropped and clears cancel_pend.
//   - MEM may accept a new instruction meanwhile.
//   - A new need_resp then waits for a later data_ok.
//   - data_ok that arrives in the same cycle as the flush is dropped; cancel_pend is not set.
//  Load extraction:
//   - off = alu_result[log2(DATA_W/8)-1:0] selects the byte lane.
//   - ld_op: 0 LD_B, 1 LD_H, 2 LD_W, 3 LD_BU, 4 LD_HU, 5 LD_WU(64), 6 LD_D(64).
//   - 7 and 64-only ops when DATA_W=32: treated as LD_W (DATA_W=32) or LD_D (DATA_W=64).
//   - Signed ops sign-extend; *U ops zero-extend.
//   - Misalignment is not checked here (EX raises ALE).
//   - final_result = res_from_mem ? extended load : alu_result.
//  Forwarding:
//   - fwd_valid = ms_valid && gr_we && dest!=0.
//   - fwd_block = fwd_valid && res_from_mem && !ms_ready_go; decode must stall.
//   - Fields other than fwd_valid/fwd_block are zero when !ms_valid.
//  Simultaneous events:
//   - flush + handoff in the same cycle: flush wins; no ms_to_ws_valid.
//   - data_ok with !need_resp && !cancel_pend: protocol error; assert in simulation, ignore in RTL.
//  Reset mid-wait: all state is cleared.
//   - The memory side is reset in the same cycle, so no stray data_ok is expected.
// STRUCTURE
//  Package mycpu_pkg:
//   - ld_op_e enum.
//   - ES_TO_MS_W / MS_TO_WS_W / MS_FWD_W localparams as functions of DATA_W, REG_AW, PC_W.
//   - Packed struct typedefs for the three buses.
//  Sub-module load_align (combinational): data, off, ld_op -> extended result.
//   - Reused later by the store-data aligner.
//  All sequential state lives in mem_stage_lsu.
// TESTING
//  1. ALU op, req_issued=0, ws_allowin=1 -> ms_to_ws_valid the cycle after capture.
//     final_result=alu_result.
//  2. LD_B, addr=0x1003, rdata=0x80AABBCC, data_ok 2 cycles late:
//     - ready_go held low 2 cycles; fwd_block=1 during the wait.
//     - Result 0xFFFFFF80.
//  3. LD_HU, addr=0x2002, rdata=0x8001_1234 -> 0x00008001.
//     LD_H same addr -> 0xFFFF8001.
//  4. data_ok=1 rdata=0x12345678 while ws_allowin=0 for 3 cycles:
//     - Buffered value delivered when ws_allowin rises.
//     - Later data_rdata glitches do not change it.
//  5. Flush 1 cycle after LD_W issued:
//     - No ms_to_ws_valid.
//     - Next LD_W accepted; first data_ok (0xDEAD) dropped.
//     - Second data_ok (0xBEEF) delivered as the result.
//  6. DATA_W=64, LD_WU addr off=4, rdata=0xF000000100000002 -> 0x00000000F0000001.
//     resetn low during wait -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types and bus-width helpers for the LA CPU pipeline.
// Default-config bus structs plus width functions for parametrised stages.
package mycpu_pkg;

  typedef enum logic [2:0] {
    LD_B   = 3'd0,
    LD_H   = 3'd1,
    LD_W   = 3'd2,
    LD_BU  = 3'd3,
    LD_HU  = 3'd4,
    LD_WU  = 3'd5,
    LD_D   = 3'd6,
    LD_RSV = 3'd7
  } ld_op_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_PC_W   = 32;

  function automatic int es_to_ms_w(int dw, int aw, int pw);
    return 6 + aw + dw + pw;
  endfunction

  function automatic int ms_to_ws_w(int dw, int aw, int pw);
    return 1 + aw + dw + pw;
  endfunction

  function automatic int ms_fwd_w(int dw, int aw);
    return 2 + aw + dw;
  endfunction

  typedef struct packed {
    logic                  req_issued;
    ld_op_e                ld_op;
    logic                  res_from_mem;
    logic                  gr_we;
    logic [DEF_REG_AW-1:0] dest;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_PC_W-1:0]   pc;
  } es_to_ms_t;

  typedef struct packed {
    logic                  gr_we;
    logic [DEF_REG_AW-1:0] dest;
    logic [DEF_DATA_W-1:0] final_result;
    logic [DEF_PC_W-1:0]   pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic                  fwd_valid;
    logic                  fwd_block;
    logic [DEF_REG_AW-1:0] dest;
    logic [DEF_DATA_W-1:0] final_result;
  } ms_fwd_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Byte-lane extraction and sign/zero extension of load data.
// Unsupported ops fall back to the full native word.
module load_align
  import mycpu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  input  ld_op_e            ld_op,
  output logic [DATA_W-1:0] result
);

  localparam bit IS64 = (DATA_W == 64);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] w_s;
  logic [DATA_W-1:0] w_u;

  assign sh  = data >> {off, 3'b000};
  assign w_s = DATA_W'($signed(sh[31:0]));
  assign w_u = DATA_W'(sh[31:0]);

  always_comb begin
    result = IS64 ? sh : w_s;
    unique case (1'b1)
      (ld_op == LD_B):  result = DATA_W'($signed(sh[7:0]));
      (ld_op == LD_H):  result = DATA_W'($signed(sh[15:0]));
      (ld_op == LD_BU): result = DATA_W'(sh[7:0]);
      (ld_op == LD_HU): result = DATA_W'(sh[15:0]);
      (ld_op == LD_W):  result = w_s;
      (ld_op == LD_WU): result = IS64 ? w_u : w_s;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: waits for data-RAM responses, aligns loads, buffers data
// across WB stalls and drops responses orphaned by a flush.
module mem_stage_lsu
  import mycpu_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int REG_AW     = 5,
  parameter  int PC_W       = 32,
  localparam int ES_TO_MS_W = es_to_ms_w(DATA_W, REG_AW, PC_W),
  localparam int MS_TO_WS_W = ms_to_ws_w(DATA_W, REG_AW, PC_W),
  localparam int MS_FWD_W   = ms_fwd_w(DATA_W, REG_AW)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ws_allowin,
  output logic                  ms_allowin,
  input  logic                  es_to_ms_valid,
  input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  input  logic                  ms_flush,
  input  logic                  data_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
  output logic [MS_FWD_W-1:0]   ms_to_ds_fwd
);

  localparam int OFF_W = $clog2(DATA_W/8);

  typedef struct packed {
    logic              req_issued;
    ld_op_e            ld_op;
    logic              res_from_mem;
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] alu_result;
    logic [PC_W-1:0]   pc;
  } es_bus_t;

  typedef struct packed {
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] final_result;
    logic [PC_W-1:0]   pc;
  } ws_bus_t;

  typedef struct packed {
    logic              fwd_valid;
    logic              fwd_block;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] final_result;
  } fwd_bus_t;

  es_bus_t           r;
  logic              ms_valid;
  logic              buf_valid;
  logic              cancel_pend;
  logic [DATA_W-1:0] rdata_buf;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ld_res;
  logic [DATA_W-1:0] final_result;
  logic              need_resp;
  logic              resp_here;
  logic              ms_ready_go;
  logic              handoff;
  ws_bus_t           ws;
  fwd_bus_t          fwd;

  assign need_resp      = ms_valid && r.req_issued;
  assign resp_here      = buf_valid || (data_ok && !cancel_pend);
  assign ms_ready_go    = !need_resp || resp_here;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
  assign handoff        = ms_to_ws_valid && ws_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      r        <= '0;
    end else begin
      if (ms_flush)
        ms_valid <= 1'b0;
      else if (ms_allowin)
        ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin)
        r <= es_bus_t'(es_to_ms_bus);
    end
  end

  // One-entry hold for data that arrived while WB was stalled
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      rdata_buf <= '0;
    end else if (ms_flush || handoff) begin
      buf_valid <= 1'b0;
    end else if (data_ok && !cancel_pend && need_resp &&
                 !ws_allowin && !buf_valid) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_rdata;
    end
  end

  // A killed load still owes one data_ok; swallow it when it comes
  always_ff @(posedge clk) begin
    if (!resetn)
      cancel_pend <= 1'b0;
    else
      cancel_pend <= (cancel_pend && !data_ok) ||
                     (need_resp && !resp_here && ms_flush);
  end

  always @(posedge clk) begin
    if (resetn && data_ok)
      assert (need_resp || cancel_pend)
        else $error("mem_stage_lsu: data_ok with no request outstanding");
  end

  assign raw = buf_valid ? rdata_buf : data_rdata;

  load_align #(.DATA_W(DATA_W)) u_align (
    .data   (raw),
    .off    (r.alu_result[OFF_W-1:0]),
    .ld_op  (r.ld_op),
    .result (ld_res)
  );

  assign final_result = r.res_from_mem ? ld_res : r.alu_result;

  always_comb begin
    ws              = '0;
    ws.gr_we        = r.gr_we;
    ws.dest         = r.dest;
    ws.final_result = final_result;
    ws.pc           = r.pc;
  end

  always_comb begin
    fwd           = '0;
    fwd.fwd_valid = ms_valid && r.gr_we && (r.dest != '0);
    fwd.fwd_block = fwd.fwd_valid && r.res_from_mem && !ms_ready_go;
    if (ms_valid) begin
      fwd.dest         = r.dest;
      fwd.final_result = final_result;
    end
  end

  assign ms_to_ws_bus = ws;
  assign ms_to_ds_fwd = fwd;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: 32-bit and 64-bit instances.
// Expected values are hand-computed constants.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         rst32, ws32, msal32, esv32, fl32, dok32, wsv32;
  logic [74:0]  esb32;
  logic [31:0]  rd32;
  logic [69:0]  wsb32;
  logic [38:0]  fwd32;

  logic         rst64, ws64, msal64, esv64, fl64, dok64, wsv64;
  logic [106:0] esb64;
  logic [63:0]  rd64;
  logic [101:0] wsb64;
  logic [70:0]  fwd64;

  mem_stage_lsu #(.DATA_W(32)) u32 (
    .clk            (clk),
    .resetn         (rst32),
    .ws_allowin     (ws32),
    .ms_allowin     (msal32),
    .es_to_ms_valid (esv32),
    .es_to_ms_bus   (esb32),
    .ms_flush       (fl32),
    .data_ok        (dok32),
    .data_rdata     (rd32),
    .ms_to_ws_valid (wsv32),
    .ms_to_ws_bus   (wsb32),
    .ms_to_ds_fwd   (fwd32)
  );

  mem_stage_lsu #(.DATA_W(64)) u64 (
    .clk            (clk),
    .resetn         (rst64),
    .ws_allowin     (ws64),
    .ms_allowin     (msal64),
    .es_to_ms_valid (esv64),
    .es_to_ms_bus   (esb64),
    .ms_flush       (fl64),
    .data_ok        (dok64),
    .data_rdata     (rd64),
    .ms_to_ws_valid (wsv64),
    .ms_to_ws_bus   (wsb64),
    .ms_to_ds_fwd   (fwd64)
  );

  function automatic logic [74:0] es32(
    logic req, logic [2:0] op, logic rfm, logic we,
    logic [4:0] d, logic [31:0] alu, logic [31:0] pc);
    return {req, op, rfm, we, d, alu, pc};
  endfunction

  function automatic logic [106:0] es64(
    logic req, logic [2:0] op, logic rfm, logic we,
    logic [4:0] d, logic [63:0] alu, logic [31:0] pc);
    return {req, op, rfm, we, d, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst32 = 0; ws32 = 1; esv32 = 0; esb32 = '0;
    fl32 = 0; dok32 = 0; rd32 = '0;
    rst64 = 0; ws64 = 1; esv64 = 0; esb64 = '0;
    fl64 = 0; dok64 = 0; rd64 = '0;
    tick();
    tick();
    chk("rst_valid", wsv32, 0);
    chk("rst_fwd", fwd32, 0);
    chk("rst_bus", wsb32, 0);
    chk("rst_allowin", msal32, 1);
    chk("rst64_valid", wsv64, 0);
    chk("rst64_fwd", fwd64, 0);
    rst32 = 1;
    rst64 = 1;

    // ALU op, no memory request
    esv32 = 1;
    esb32 = es32(0, 3'd2, 0, 1, 5'd3, 32'h1234, 32'h100);
    tick();
    esv32 = 0;
    #1;
    chk("t1_valid", wsv32, 1);
    chk("t1_result", wsb32[63:32], 32'h1234);
    chk("t1_pc", wsb32[31:0], 32'h100);
    chk("t1_fwd", fwd32[38:37], 2'b10);
    chk("t1_fwd_dest", fwd32[36:32], 5'd3);
    tick();
    chk("t1_drain", wsv32, 0);

    // LD_B with response two cycles late
    esv32 = 1;
    esb32 = es32(1, 3'd0, 1, 1, 5'd5, 32'h1003, 32'h104);
    tick();
    esv32 = 0;
    #1;
    chk("t2_wait0", wsv32, 0);
    chk("t2_block0", fwd32[37], 1);
    chk("t2_allowin0", msal32, 0);
    tick();
    chk("t2_wait1", wsv32, 0);
    chk("t2_block1", fwd32[37], 1);
    tick();
    dok32 = 1;
    rd32 = 32'h80AABBCC;
    #1;
    chk("t2_valid", wsv32, 1);
    chk("t2_result", wsb32[63:32], 32'hFFFFFF80);
    chk("t2_block_clr", fwd32[37], 0);
    tick();
    dok32 = 0;
    #1;

    // LD_HU then LD_H back-to-back, zero-wait
    esv32 = 1;
    esb32 = es32(1, 3'd4, 1, 1, 5'd6, 32'h2002, 32'h108);
    tick();
    esb32 = es32(1, 3'd1, 1, 1, 5'd6, 32'h2002, 32'h10C);
    dok32 = 1;
    rd32 = 32'h80011234;
    #1;
    chk("t3_hu_valid", wsv32, 1);
    chk("t3_hu_result", wsb32[63:32], 32'h00008001);
    chk("t3_allowin", msal32, 1);
    tick();
    esv32 = 0;
    #1;
    chk("t3_h_result", wsb32[63:32], 32'hFFFF8001);
    chk("t3_h_pc", wsb32[31:0], 32'h10C);
    tick();
    dok32 = 0;
    #1;

    // response arrives while WB stalls for three cycles
    esv32 = 1;
    esb32 = es32(1, 3'd2, 1, 1, 5'd7, 32'h3000, 32'h110);
    ws32 = 0;
    tick();
    esv32 = 0;
    dok32 = 1;
    rd32 = 32'h12345678;
    #1;
    chk("t4_valid", wsv32, 1);
    chk("t4_result", wsb32[63:32], 32'h12345678);
    tick();
    dok32 = 0;
    rd32 = 32'hFFFFFFFF;
    #1;
    chk("t4_hold1", wsb32[63:32], 32'h12345678);
    chk("t4_stall", msal32, 0);
    tick();
    rd32 = 32'h00000000;
    #1;
    chk("t4_hold2", wsb32[63:32], 32'h12345678);
    chk("t4_hold2_valid", wsv32, 1);
    tick();
    ws32 = 1;
    rd32 = 32'hAAAAAAAA;
    #1;
    chk("t4_out_valid", wsv32, 1);
    chk("t4_out_result", wsb32[63:32], 32'h12345678);
    chk("t4_out_allowin", msal32, 1);
    tick();
    chk("t4_done", wsv32, 0);

    // flush while waiting; stale response must be dropped
    esv32 = 1;
    esb32 = es32(1, 3'd2, 1, 1, 5'd8, 32'h4000, 32'h120);
    tick();
    esv32 = 0;
    #1;
    chk("t5_wait", wsv32, 0);
    tick();
    fl32 = 1;
    #1;
    chk("t5_flush_valid", wsv32, 0);
    tick();
    fl32 = 0;
    esv32 = 1;
    esb32 = es32(1, 3'd2, 1, 1, 5'd9, 32'h4004, 32'h200);
    #1;
    chk("t5_allowin", msal32, 1);
    chk("t5_idle", wsv32, 0);
    tick();
    esv32 = 0;
    dok32 = 1;
    rd32 = 32'h0000DEAD;
    #1;
    chk("t5_drop_valid", wsv32, 0);
    chk("t5_drop_block", fwd32[37], 1);
    tick();
    rd32 = 32'h0000BEEF;
    #1;
    chk("t5_valid", wsv32, 1);
    chk("t5_result", wsb32[63:32], 32'h0000BEEF);
    chk("t5_pc", wsb32[31:0], 32'h200);
    tick();
    dok32 = 0;
    #1;

    // dest=0 never forwards; flush beats handoff
    esv32 = 1;
    esb32 = es32(0, 3'd2, 0, 1, 5'd0, 32'h55, 32'h130);
    tick();
    esv32 = 0;
    fl32 = 1;
    #1;
    chk("t6_fwd_dest0", fwd32[38], 0);
    chk("t6_flush_valid", wsv32, 0);
    tick();
    fl32 = 0;
    #1;
    chk("t6_gone", wsv32, 0);

    // 64-bit LD_WU at byte offset 4
    esv64 = 1;
    esb64 = es64(1, 3'd5, 1, 1, 5'd9, 64'h5004, 32'h300);
    tick();
    esv64 = 0;
    dok64 = 1;
    rd64 = 64'hF000000100000002;
    #1;
    chk("t7_valid", wsv64, 1);
    chk("t7_result", wsb64[95:32], 64'h00000000F0000001);
    tick();
    dok64 = 0;
    #1;

    // reset while a 64-bit load is waiting
    esv64 = 1;
    esb64 = es64(1, 3'd6, 1, 1, 5'd10, 64'h6000, 32'h308);
    tick();
    esv64 = 0;
    #1;
    chk("t8_block", fwd64[69], 1);
    chk("t8_wait", wsv64, 0);
    rst64 = 0;
    tick();
    chk("t8_rst_valid", wsv64, 0);
    chk("t8_rst_fwd", fwd64, 0);
    chk("t8_rst_bus", wsb64, 0);
    rst64 = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
